// File: rtl/qpu_instr_encoder.sv
// qpu_instr_encoder: packs field-level QPU ops into instruction words and streams them to instruction memory
`timescale 1ns/1ps
module qpu_instr_encoder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [4:0]        enc_op,
  input  logic [4:0]        enc_rd,
  input  logic [4:0]        enc_rs1,
  input  logic [4:0]        enc_rs2,
  input  logic [31:0]       enc_imm,
  input  logic [8:0]        enc_gate1,
  input  logic [8:0]        enc_gate2,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] fifo_addr [2];
  logic [31:0] fifo_word [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic [31:0] word;
  logic legal, acc, push, pop;
  logic [4:0] i_hi;
  logic [8:0] i_lo;
  logic [1:0] fl;
  assign i_hi = enc_imm[13:9];
  assign i_lo = enc_imm[8:0];
  assign fl = enc_op[1:0] ^ 2'b10;
  assign enc_ready = (state == RUN) && (count != 2'd2);
  assign acc = enc_valid & enc_ready;
  assign push = acc & legal;
  assign wr_valid = count != 2'd0;
  assign pop = wr_valid & wr_ready;
  assign wr_addr = fifo_addr[rd_ptr];
  assign wr_data = fifo_word[rd_ptr];
  assign busy = state != IDLE;
  // Legality: opcode in range and immediate fits the field the op encodes
  always_comb begin
    legal = (enc_op <= 5'd19) &&
            ((enc_op <= 5'd9) ? (&enc_imm[31:13] | ~|enc_imm[31:13]) :
             (enc_op == 5'd14 || enc_op == 5'd16) ? ~|enc_imm[31:14] : 1'b1);
  end
  // Instruction word layout per op; func of the 4-op groups is the low op bits rotated by 2
  always_comb begin
    word = 32'h0;
    case (enc_op)
      5'd0:                      word = {3'b010, i_hi, i_lo, enc_rs1, enc_rd, 2'b00, 2'b00, 1'b0};
      5'd1:                      word = {3'b010, enc_rs2, i_lo, enc_rs1, i_hi, 2'b01, 2'b00, 1'b0};
      5'd2, 5'd3, 5'd4, 5'd5:    word = {1'b0, fl, enc_rs2, i_lo, enc_rs1, i_hi, 2'b11, 2'b00, 1'b0};
      5'd6, 5'd7, 5'd8, 5'd9:    word = {1'b0, fl, i_hi, i_lo, enc_rs1, enc_rd, 2'b00, 2'b01, 1'b0};
      5'd10, 5'd11, 5'd12, 5'd13: word = {1'b0, fl, enc_rs2, 9'd0, enc_rs1, enc_rd, 2'b01, 2'b01, 1'b0};
      5'd14:                     word = {3'b010, enc_rs2, i_lo, i_hi, enc_rd, 2'b10, 2'b01, 1'b0};
      5'd15:                     word = {3'b000, 5'd0, 9'd0, enc_rs1, enc_rd, 2'b11, 2'b01, 1'b0};
      5'd16:                     word = {3'b010, enc_rs2, i_lo, i_hi, enc_rd, 2'b00, 2'b11, 1'b0};
      5'd17:                     word = {3'b111, enc_rs2, enc_gate2, enc_rs1, enc_gate1, 1'b1};
      5'd18:                     word = {3'b011, 5'd0, 9'd0, enc_rs1, 9'h1FF, 1'b1};
      5'd19:                     word = 32'h0000_0004;
      default:                   word = 32'h0;
    endcase
  end
  // Next state: WFI closes intake, the WFI write itself (always the last entry) ends the run
  always_comb begin
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN) ? ((push && enc_op == 5'd19) ? DRAIN : RUN) :
               ((pop && count == 2'd1) ? IDLE : DRAIN);
  end
  // State, address counter, FIFO and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr_cnt <= '0;
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      fifo_word[0] <= '0;
      fifo_word[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
      done <= 1'b0;
      err <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= state_nx;
      err <= acc & ~legal;
      done <= (state == DRAIN) && pop && (count == 2'd1);
      if (state == IDLE && start) addr_cnt <= base_addr & ~ADDR_W'(3);
      else if (push) addr_cnt <= addr_cnt + ADDR_W'(4);
      if (state == IDLE && start) word_cnt <= '0;
      else if (pop && ~&word_cnt) word_cnt <= word_cnt + 16'd1;
      if (push) begin
        fifo_addr[wr_ptr] <= addr_cnt;
        fifo_word[wr_ptr] <= word;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_qpu_instr_encoder.sv
// tb_qpu_instr_encoder: vector table, directed corner cases and randomized ops against a field-level model
`timescale 1ns/1ps
module tb_qpu_instr_encoder;
  logic clk = 0, rst = 1, start = 0, enc_valid = 0, wr_ready = 0;
  logic [31:0] base_addr = 0, enc_imm = 0;
  logic [4:0] enc_op = 0, enc_rd = 0, enc_rs1 = 0, enc_rs2 = 0;
  logic [8:0] enc_gate1 = 0, enc_gate2 = 0;
  logic enc_ready, wr_valid, busy, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] word_cnt;
  logic b_enc_ready, b_wr_valid, b_busy, b_done, b_err;
  logic [7:0] b_wr_addr;
  logic [31:0] b_wr_data;
  logic [15:0] b_word_cnt;

  qpu_instr_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_op(enc_op), .enc_rd(enc_rd),
    .enc_rs1(enc_rs1), .enc_rs2(enc_rs2), .enc_imm(enc_imm), .enc_gate1(enc_gate1),
    .enc_gate2(enc_gate2), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt));

  qpu_instr_encoder #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[7:0]),
    .enc_valid(enc_valid), .enc_ready(b_enc_ready), .enc_op(enc_op), .enc_rd(enc_rd),
    .enc_rs1(enc_rs1), .enc_rs2(enc_rs2), .enc_imm(enc_imm), .enc_gate1(enc_gate1),
    .enc_gate2(enc_gate2), .wr_valid(b_wr_valid), .wr_ready(wr_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy), .done(b_done), .err(b_err), .word_cnt(b_word_cnt));

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-op field tables for ops 0..16: func, opH, opL
  int fn_t [17] = '{2, 2, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 2, 0, 2};
  int oh_t [17] = '{0, 1, 3, 3, 3, 3, 0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 0};
  int ol_t [17] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3};

  function automatic logic [31:0] model_word(input int op, input int rd, input int rs1, input int rs2,
                                             input logic [31:0] imm, input int g1, input int g2,
                                             output bit ok);
    longint w;
    int lo, hi, a, b, c, d;
    lo = int'(imm & 32'h1FF);
    hi = int'((imm >> 9) & 32'h1F);
    a = 0; b = 0; c = 0; d = 0; w = 0;
    ok = op <= 19;
    if (op <= 9) ok = ($signed(imm) >= -8192) && ($signed(imm) <= 8191);
    if (op == 14 || op == 16) ok = imm < 32'd16384;
    if (op == 0 || (op >= 6 && op <= 9)) begin a = hi; b = lo; c = rs1; d = rd; end
    if (op >= 1 && op <= 5) begin a = rs2; b = lo; c = rs1; d = hi; end
    if (op >= 10 && op <= 13) begin a = rs2; c = rs1; d = rd; end
    if (op == 14 || op == 16) begin a = rs2; b = lo; c = hi; d = rd; end
    if (op == 15) begin c = rs1; d = rd; end
    if (op <= 16)
      w = (longint'(fn_t[op]) << 29) + (longint'(a) << 24) + (longint'(b) << 15) +
          (longint'(c) << 10) + (longint'(d) << 5) + (longint'(oh_t[op]) << 3) + (longint'(ol_t[op]) << 1);
    else if (op == 17)
      w = (longint'(7) << 29) + (longint'(rs2) << 24) + (longint'(g2) << 15) +
          (longint'(rs1) << 10) + (longint'(g1) << 1) + 1;
    else if (op == 18)
      w = (longint'(3) << 29) + (longint'(rs1) << 10) + 511 * 2 + 1;
    else if (op == 19)
      w = 4;
    return w[31:0];
  endfunction

  typedef struct { logic [31:0] addr; logic [31:0] data; bit wfi; } ent_t;
  ent_t exp_q[$];
  logic [31:0] cap_a[$], cap_d[$];
  logic [7:0] cap8[$];
  logic [31:0] m_addr = 0;
  bit err_pend = 0, done_pend = 0, mon_en = 0, rand_bp = 0;
  int err_seen = 0, legal_n = 0;
  ent_t me;
  bit mok;
  logic [31:0] mw;

  // Scoreboard: sample at negedge, where inputs and outputs are stable until the next posedge
  always @(negedge clk) if (mon_en) begin
    chk("err", err, err_pend);
    chk("done", done, done_pend);
    if (err) err_seen++;
    err_pend = 0;
    done_pend = 0;
    if (wr_valid && wr_ready) begin
      cap_a.push_back(wr_addr);
      cap_d.push_back(wr_data);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
      end else begin
        me = exp_q.pop_front();
        chk("wr_addr", wr_addr, me.addr);
        chk("wr_data", wr_data, me.data);
        done_pend = me.wfi;
      end
    end
    if (b_wr_valid && wr_ready) cap8.push_back(b_wr_addr);
    if (enc_valid && enc_ready) begin
      mw = model_word(enc_op, enc_rd, enc_rs1, enc_rs2, enc_imm, enc_gate1, enc_gate2, mok);
      if (mok) begin
        exp_q.push_back('{m_addr, mw, enc_op == 5'd19});
        m_addr = m_addr + 32'd4;
        legal_n++;
      end else err_pend = 1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) wr_ready = $urandom_range(0, 3) != 0;
  end

  task automatic do_reset();
    mon_en = 0;
    rst = 1;
    enc_valid = 0;
    start = 0;
    @(posedge clk);
    #1;
    exp_q.delete();
    err_pend = 0;
    done_pend = 0;
    @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;
  endtask

  task automatic do_start(input logic [31:0] b, input bit taken);
    base_addr = b;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    if (taken) m_addr = b & ~32'h3;
  endtask

  task automatic put(input int op, input logic [31:0] imm);
    enc_op = op[4:0];
    enc_imm = imm;
    enc_valid = 1;
  endtask

  task automatic wait_acc();
    int n;
    n = 0;
    @(negedge clk);
    while (!enc_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!enc_ready) begin
      total++;
      $display("FAIL accept_timeout: got enc_ready 0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    enc_valid = 0;
  endtask

  task automatic send(input int op, input logic [31:0] imm);
    put(op, imm);
    wait_acc();
  endtask

  task automatic wait_done();
    int n;
    bit seen;
    seen = 0;
    for (n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    chk("busy_after_done", busy, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct { int op; logic [31:0] imm; logic [31:0] word; } vec_t;
  vec_t tbl [20];

  initial begin
    int e0;
    tbl[0]  = '{0,  32'hFFFF_EB55, 32'h55AA_A640};
    tbl[1]  = '{1,  32'hFFFF_EB55, 32'h4AAA_A6A8};
    tbl[2]  = '{2,  32'hFFFF_EB55, 32'h0AAA_A6B8};
    tbl[3]  = '{3,  32'hFFFF_EB55, 32'h2AAA_A6B8};
    tbl[4]  = '{4,  32'hFFFF_EB55, 32'h4AAA_A6B8};
    tbl[5]  = '{5,  32'hFFFF_EB55, 32'h6AAA_A6B8};
    tbl[6]  = '{6,  32'hFFFF_EB55, 32'h15AA_A642};
    tbl[7]  = '{7,  32'hFFFF_EB55, 32'h35AA_A642};
    tbl[8]  = '{8,  32'hFFFF_EB55, 32'h55AA_A642};
    tbl[9]  = '{9,  32'hFFFF_EB55, 32'h75AA_A642};
    tbl[10] = '{10, 32'hFFFF_EB55, 32'h0A00_264A};
    tbl[11] = '{11, 32'hFFFF_EB55, 32'h2A00_264A};
    tbl[12] = '{12, 32'hFFFF_EB55, 32'h4A00_264A};
    tbl[13] = '{13, 32'hFFFF_EB55, 32'h6A00_264A};
    tbl[14] = '{14, 32'h0000_2B55, 32'h4AAA_D652};
    tbl[15] = '{15, 32'hFFFF_EB55, 32'h0000_265A};
    tbl[16] = '{16, 32'h0000_2B55, 32'h4AAA_D646};
    tbl[17] = '{17, 32'hFFFF_EB55, 32'hEA0F_27C3};
    tbl[18] = '{18, 32'hFFFF_EB55, 32'h6000_27FF};
    tbl[19] = '{19, 32'hFFFF_EB55, 32'h0000_0004};
    enc_rd = 18; enc_rs1 = 9; enc_rs2 = 10; enc_gate1 = 9'h1E1; enc_gate2 = 9'h01E;

    do_reset();
    chk("rst_enc_ready", enc_ready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_word_cnt", word_cnt, 0);

    // ADDI latency and word_cnt
    wr_ready = 1;
    do_start(32'h100, 1);
    chk("start_busy", busy, 1);
    chk("start_enc_ready", enc_ready, 1);
    send(6, 32'hFFFF_EB55);
    chk("addi_wr_valid", wr_valid, 1);
    chk("addi_wr_addr", wr_addr, 32'h100);
    chk("addi_wr_data", wr_data, 32'h15AA_A642);
    @(posedge clk);
    #1;
    chk("addi_word_cnt", word_cnt, 1);
    send(19, 0);
    wait_done();

    // Full-set sweep against the hand-computed table
    do_start(32'h100, 1);
    cap_a.delete();
    cap_d.delete();
    for (int i = 0; i < 20; i++) send(tbl[i].op, tbl[i].imm);
    wait_done();
    chk("sweep_count", cap_d.size(), 20);
    for (int i = 0; i < 20 && i < cap_d.size(); i++) begin
      chk($sformatf("sweep_word_op%0d", tbl[i].op), cap_d[i], tbl[i].word);
      chk($sformatf("sweep_addr_op%0d", tbl[i].op), cap_a[i], 32'h100 + 32'(4 * i));
    end
    chk("sweep_word_cnt", word_cnt, 20);

    // Backpressure: two accepted, third held off, head stable; start while busy ignored
    wr_ready = 0;
    do_start(32'h200, 1);
    chk("start_clears_cnt", word_cnt, 0);
    send(6, 32'h5);
    do_start(32'h800, 0);
    send(10, 0);
    put(11, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_enc_ready", enc_ready, 0);
      chk("bp_head_addr", wr_addr, 32'h200);
      chk("bp_head_valid", wr_valid, 1);
    end
    @(posedge clk);
    #1;
    wr_ready = 1;
    wait_acc();
    send(19, 0);
    wait_done();
    chk("bp_word_cnt", word_cnt, 4);

    // Rejects: no writes, err pulses, address unchanged
    do_start(32'h300, 1);
    e0 = err_seen;
    send(6, 32'h0000_2000);
    send(25, 0);
    send(14, 32'h0000_4000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rej_err_pulses", err_seen - e0, 3);
    chk("rej_word_cnt", word_cnt, 0);
    send(10, 0);
    chk("rej_next_addr", wr_addr, 32'h300);
    send(19, 0);
    wait_done();

    // Address wrap on the 8-bit instance
    do_reset();
    wr_ready = 1;
    do_start(32'hFC, 1);
    cap8.delete();
    send(6, 32'h1);
    send(10, 0);
    send(19, 0);
    wait_done();
    chk("wrap_count", cap8.size(), 3);
    if (cap8.size() == 3) begin
      chk("wrap_addr0", cap8[0], 32'hFC);
      chk("wrap_addr1", cap8[1], 32'h00);
      chk("wrap_addr2", cap8[2], 32'h04);
    end

    // Reset mid-run with two words buffered
    wr_ready = 0;
    do_start(32'h400, 1);
    send(6, 32'h7);
    send(12, 0);
    mon_en = 0;
    rst = 1;
    #1;
    chk("mid_enc_ready", enc_ready, 0);
    chk("mid_wr_valid", wr_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    chk("mid_wr_addr", wr_addr, 0);
    chk("mid_wr_data", wr_data, 0);
    chk("mid_word_cnt", word_cnt, 0);
    exp_q.delete();
    err_pend = 0;
    done_pend = 0;
    @(posedge clk);
    #1;
    rst = 0;
    wr_ready = 1;
    mon_en = 1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized ops with random backpressure
    do_start($urandom, 1);
    legal_n = 0;
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      int op, k;
      logic [31:0] imm;
      logic [31:0] edge_v [6];
      edge_v = '{32'h1FFF, 32'hFFFF_E000, 32'h2000, 32'hFFFF_DFFF, 32'h3FFF, 32'h4000};
      op = $urandom_range(0, 23);
      if (op == 19) op = 20;
      k = $urandom_range(0, 3);
      imm = (k == 0) ? 32'($urandom_range(0, 32'h1FFF)) :
            (k == 1) ? -32'($urandom_range(0, 8192)) :
            (k == 2) ? $urandom : edge_v[$urandom_range(0, 5)];
      enc_rd = 5'($urandom); enc_rs1 = 5'($urandom); enc_rs2 = 5'($urandom);
      enc_gate1 = 9'($urandom); enc_gate2 = 9'($urandom);
      send(op, imm);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    send(19, 0);
    wait_done();
    rand_bp = 0;
    wr_ready = 1;
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_word_cnt", word_cnt, 32'(legal_n));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
